// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer.
// Holds default sizing, the FSM state type, source index names and the
// per-routine END_ADDR table (the terminator word address of each routine).
package vend_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned AW      = 3;
  localparam int unsigned IW      = 19;

  localparam int unsigned SRC_COIN1  = 0;
  localparam int unsigned SRC_COIN5  = 1;
  localparam int unsigned SRC_COIN10 = 2;
  localparam int unsigned SRC_VEND   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  typedef logic [NUM_SRC-1:0][AW-1:0] end_addr_t;

  // Entry i is the END_ADDR of routine i; entry 3 is written first.
  localparam end_addr_t END_ADDR = {3'd7, 3'd5, 3'd4, 3'd3};

endpackage

// File: rtl/vend_req_counter.sv
// Per-source pending request counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req      : one-cycle request pulse from the source
//   grant    : sequencer consumes one pending request this cycle
//   count    : 2-bit pending count, saturates at 3
//   ovf      : sticky flag, set when a request is dropped at saturation
import vend_pkg::*;

module vend_req_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       grant,
  output logic [1:0] count,
  output logic       ovf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case ({req, grant})
        2'b10: begin
          if (count == 2'd3) ovf <= 1'b1;
          else               count <= count + 2'd1;
        end
        2'b01: begin
          if (count != '0) count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Microcode sequencer for a vending machine controller.
// Accumulates request pulses per source, grants the lowest-index pending
// source when idle, and streams that routine's instructions (addresses
// 1..END_ADDR-1) to the datapath with a valid/ready handshake.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-source request pulses
//   rom_sel     : routine select to the external ROM mux
//   rom_addr    : word address to the selected ROM
//   rom_dout    : combinational ROM read data
//   instr       : instruction to the datapath (= rom_dout)
//   instr_valid : instr is issuable this cycle
//   instr_ready : datapath accepts instr
//   busy        : a routine is in progress
//   done        : one-cycle pulse after a routine's last transfer
//   req_ovf     : sticky per-source overflow flags
import vend_pkg::*;

module vend_sequencer #(
  parameter int unsigned                NUM_SRC     = vend_pkg::NUM_SRC,
  parameter int unsigned                AW          = vend_pkg::AW,
  parameter int unsigned                IW          = vend_pkg::IW,
  parameter logic [NUM_SRC-1:0][AW-1:0] ROUTINE_END = vend_pkg::END_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic [1:0]         rom_sel,
  output logic [AW-1:0]      rom_addr,
  input  logic [IW-1:0]      rom_dout,
  output logic [IW-1:0]      instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic [NUM_SRC-1:0] req_ovf
);

  state_t                    state, state_next;
  logic [NUM_SRC-1:0][1:0]   count;
  logic [NUM_SRC-1:0]        pending;
  logic [NUM_SRC-1:0]        grant;
  logic                      any_pending;
  logic [1:0]                grant_idx;
  logic [AW-1:0]             cur_end;
  logic [AW-1:0]             grant_end;
  logic                      xfer;
  logic                      last;
  logic                      start;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    vend_req_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .req   (req[g]),
      .grant (grant[g]),
      .count (count[g]),
      .ovf   (req_ovf[g])
    );
    assign pending[g] = (count[g] != '0);
  end

  // Fixed priority: scan downward so the lowest pending index is kept.
  always_comb begin
    grant_idx   = '0;
    any_pending = 1'b0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (pending[i-1]) begin
        grant_idx   = 2'(i - 1);
        any_pending = 1'b1;
      end
    end
  end

  assign start     = (state == IDLE) && any_pending;
  assign cur_end   = ROUTINE_END[rom_sel];
  assign grant_end = ROUTINE_END[grant_idx];
  assign last      = (rom_addr == cur_end - AW'(1));

  always_comb begin
    grant = '0;
    if (start) grant[grant_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; an empty routine (END_ADDR < 2) skips ISSUE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_pending) state_next = (grant_end < AW'(2)) ? DONE : ISSUE;
      ISSUE:   if (xfer && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ROM pointer: loaded on grant, advanced only on a non-final transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_sel  <= '0;
      rom_addr <= '0;
    end else if (start) begin
      rom_sel  <= grant_idx;
      rom_addr <= AW'(1);
    end else if ((state == ISSUE) && xfer && !last) begin
      rom_addr <= rom_addr + AW'(1);
    end
  end

  // Outputs
  always_comb begin
    instr_valid = (state == ISSUE);
    busy        = (state != IDLE);
    done        = (state == DONE);
    instr       = rom_dout;
    xfer        = instr_valid && instr_ready;
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001: Parameter NUM_SRC, default 4; number of requesters/ROM routines (index 0 = 1-unit coin, 1 = 5-unit, 2 = 10-unit, 3 = vend).
REQ-002: Parameter AW, default 3; ROM address width (8-word routines).
REQ-003: Parameter IW, default 19; instruction word width.
REQ-004: Port clk  in  1  single clock; all state updates on rising edge.
REQ-005: Port rst  in  1  synchronous, active-high reset.
REQ-006: Port req  in  NUM_SRC  one-cycle request pulses, one per routine.
REQ-007: Port rom_sel  out  2  selects which routine ROM drives rom_dout.
REQ-008: Port rom_addr  out  AW  word address to selected ROM.
REQ-009: Port rom_dout  in  IW  combinational ROM read data for rom_sel/rom_addr.
REQ-010: Port instr  out  IW  instruction to datapath; equals rom_dout.
REQ-011: Port instr_valid  out  1  instr is issuable this cycle.
REQ-012: Port instr_ready  in  1  datapath accepts instr; transfer = instr_valid & instr_ready.
REQ-013: Port busy  out  1  a routine is in progress.
REQ-014: Port done  out  1  one-cycle pulse after last instruction of a routine transfers.
REQ-015: Port req_ovf  out  NUM_SRC  sticky per-source overflow flags.

Function
REQ-016: Each source SHALL have a 2-bit pending counter: +1 on req pulse, -1 on grant, unchanged when both occur in the same cycle, saturating at 3.
REQ-017: A req pulse arriving with counter at 3 and no same-cycle grant SHALL be dropped and set req_ovf[i], held until reset.
REQ-018: States SHALL be IDLE, ISSUE, DONE.
REQ-019: IDLE: if any counter nonzero, grant lowest-index nonzero source (fixed priority), load rom_sel with it, rom_addr <= 1, go ISSUE next cycle; else stay.
REQ-020: Address 0 of every routine is a dummy and SHALL never be issued.
REQ-021: Each routine SHALL have a constant END_ADDR; addresses 1..END_ADDR-1 are issued, END_ADDR is the terminator word and is not issued.
REQ-022: ISSUE: instr_valid = 1; on transfer, if rom_addr == END_ADDR-1 go DONE, else rom_addr increments by 1; without transfer, rom_sel/rom_addr/instr SHALL hold stable.
REQ-023: DONE: done = 1 for exactly one cycle, then IDLE; a new grant SHALL not occur before IDLE (minimum one idle cycle between routines).
REQ-024: Latency: req pulse in cycle t with sequencer idle -> instr_valid first asserted in cycle t+2.
REQ-025: busy SHALL be 1 in ISSUE and DONE, 0 in IDLE.
REQ-026: A routine in progress SHALL never be preempted by a higher-priority request; requests keep accumulating in counters.
REQ-027: instr_valid SHALL be 0 outside ISSUE; instr is don't-care there.
REQ-028: END_ADDR < 2 for a routine SHALL be treated as empty: grant consumed, go directly to DONE, no instruction issued.

Reset
REQ-029: On rst: state IDLE, all counters 0, req_ovf 0, rom_sel 0, rom_addr 0, instr_valid 0, busy 0, done 0.
REQ-030: rst SHALL override all activity, including mid-routine; the interrupted routine is abandoned, not resumed; req during rst is ignored.

Structure
REQ-031: Shared package vend_pkg SHALL hold IW, AW, NUM_SRC, state enum, source index constants, and END_ADDR table (1-unit routine END_ADDR = 3).
REQ-032: Pending counter + overflow logic SHALL be one sub-module, vend_req_counter, instantiated NUM_SRC times.
REQ-033: ROMs and rom_dout mux SHALL be outside this block.

Verification
REQ-034: Reset, req[0] pulse at t, instr_ready = 1, ROM0 END_ADDR 3 -> valid at t+2 addr 1 (instr 19'h70001), t+3 addr 2 (19'h04040), done at t+4, busy low t+5.
REQ-035: req[0] and req[3] same cycle -> routine 0 completes, then routine 3 starts, counters both end at 0.
REQ-036: req[1] pulsed 4 times while busy -> counter 3, req_ovf[1] = 1, routine 1 runs exactly 3 times.
REQ-037: instr_ready low for 3 cycles at addr 1 -> instr_valid held, rom_addr stays 1, instr unchanged; advances on first ready cycle.
REQ-038: rst asserted at addr 2 of routine 0 with req[2] pending -> all outputs reset values next cycle, req[2] lost, no done pulse.
REQ-039: req[0] pulse coinciding with grant of source 0 (count 1) -> count stays 1, routine 0 runs twice total.
